// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel stage: buffers two image lines and
// emits one neighbourhood per interior pixel with valid/ready and end-of-frame flag.
module sobel_window_gen #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [DATA_WIDTH-1:0] pixel_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] p0_o,
    output logic [DATA_WIDTH-1:0] p1_o,
    output logic [DATA_WIDTH-1:0] p2_o,
    output logic [DATA_WIDTH-1:0] p3_o,
    output logic [DATA_WIDTH-1:0] p4_o,
    output logic [DATA_WIDTH-1:0] p5_o,
    output logic [DATA_WIDTH-1:0] p6_o,
    output logic [DATA_WIDTH-1:0] p7_o,
    output logic [DATA_WIDTH-1:0] p8_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] ColLast = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] ColTwo  = CW'(2);
    localparam logic [RW-1:0] RowTwo  = RW'(2);

    logic [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;

    logic [DATA_WIDTH-1:0] win_q [9];
    logic [DATA_WIDTH-1:0] win_d [9];
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  accept;

    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;
    assign lb0_rd  = lb0_q[col_q];
    assign lb1_rd  = lb1_q[col_q];

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        valid_d = valid_q;
        last_d  = last_q;
        win_d   = win_q;
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_d[3*i]   = win_q[3*i+1];
                win_d[3*i+1] = win_q[3*i+2];
            end
            win_d[2] = lb1_rd;
            win_d[5] = lb0_rd;
            win_d[8] = pixel_i;
            // Border centres are never emitted; this also hides stale line-buffer data.
            valid_d  = (row_q >= RowTwo) && (col_q >= ColTwo);
            last_d   = (row_q == RowLast) && (col_q == ColLast);
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            win_q   <= '{default: '0};
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            win_q   <= win_d;
        end
    end

    // Line buffers carry no reset; their contents only reach the outputs once row >= 2.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_rd;
            lb0_q[col_q] <= pixel_i;
        end
    end

    assign p0_o    = win_q[0];
    assign p1_o    = win_q[1];
    assign p2_o    = win_q[2];
    assign p3_o    = win_q[3];
    assign p4_o    = win_q[4];
    assign p5_o    = win_q[5];
    assign p6_o    = win_q[6];
    assign p7_o    = win_q[7];
    assign p8_o    = win_q[8];
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: a 4x4 instance for the directed frames and a 24x16 instance
// for randomised gaps and backpressure, both checked against a 2-D image scoreboard.
module tb_sobel_window_gen;

    localparam int RW_W = 24;
    localparam int RW_H = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sel = 1'b0;
    logic       valid_in = 1'b0;
    logic       ready_in = 1'b1;
    logic [7:0] pixel_in = '0;

    always #5 clk = ~clk;

    logic       v4, r4, ready_4, valid_4, last_4;
    logic       vr, rr, ready_r, valid_r, last_r;
    logic [7:0] w4 [9];
    logic [7:0] wr [9];
    logic [7:0] m_win [9];
    logic       m_ready, m_valid, m_last;

    assign v4 = valid_in && !sel;
    assign vr = valid_in && sel;
    assign r4 = sel ? 1'b1 : ready_in;
    assign rr = sel ? ready_in : 1'b1;

    always_comb begin
        for (int i = 0; i < 9; i++) m_win[i] = sel ? wr[i] : w4[i];
        m_ready = sel ? ready_r : ready_4;
        m_valid = sel ? valid_r : valid_4;
        m_last  = sel ? last_r : last_4;
    end

    sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_WIDTH(8)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n), .pixel_i(pixel_in), .valid_i(v4), .ready_o(ready_4),
        .p0_o(w4[0]), .p1_o(w4[1]), .p2_o(w4[2]), .p3_o(w4[3]), .p4_o(w4[4]),
        .p5_o(w4[5]), .p6_o(w4[6]), .p7_o(w4[7]), .p8_o(w4[8]),
        .valid_o(valid_4), .ready_i(r4), .last_o(last_4)
    );

    sobel_window_gen #(.IMG_WIDTH(RW_W), .IMG_HEIGHT(RW_H), .DATA_WIDTH(8)) dutr (
        .clk_i(clk), .reset_n_i(reset_n), .pixel_i(pixel_in), .valid_i(vr), .ready_o(ready_r),
        .p0_o(wr[0]), .p1_o(wr[1]), .p2_o(wr[2]), .p3_o(wr[3]), .p4_o(wr[4]),
        .p5_o(wr[5]), .p6_o(wr[6]), .p7_o(wr[7]), .p8_o(wr[8]),
        .valid_o(valid_r), .ready_i(rr), .last_o(last_r)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          img_w = 4;
    int          img_h = 4;
    int          mr = 0;
    int          mc = 0;
    logic [7:0]  img [RW_W*RW_H];
    logic [72:0] exp_q [$];
    logic [71:0] cap_w [$];
    logic        cap_l [$];
    int          stall_left = 0;
    bit          rand_rdy = 0;
    bit          gaps = 0;
    bit          prev_stall = 0;
    logic [73:0] prev_out;

    typedef struct packed {
        int          idx;
        logic        last;
        logic [71:0] w;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [71:0] m_pack();
        return {m_win[0], m_win[1], m_win[2], m_win[3], m_win[4],
                m_win[5], m_win[6], m_win[7], m_win[8]};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] px);
        int b;
        img[mr*img_w + mc] = px;
        if (mr >= 2 && mc >= 2) begin
            b = (mr - 2) * img_w + mc - 2;
            exp_q.push_back({(mr == img_h - 1) && (mc == img_w - 1),
                             img[b], img[b+1], img[b+2],
                             img[b+img_w], img[b+img_w+1], img[b+img_w+2],
                             img[b+2*img_w], img[b+2*img_w+1], img[b+2*img_w+2]});
        end
        if (mc == img_w - 1) begin
            mc = 0;
            mr = (mr == img_h - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] px, output bit acc);
        logic        rdy;
        logic [71:0] w;
        logic [72:0] e;
        @(negedge clk);
        if (stall_left > 0 && m_valid) begin
            rdy = 1'b0;
            stall_left--;
        end else if (rand_rdy) begin
            rdy = ($urandom_range(0, 3) != 0);
        end else begin
            rdy = 1'b1;
        end
        valid_in = v;
        pixel_in = px;
        ready_in = rdy;
        #4;
        w = m_pack();
        if (prev_stall) check("hold under stall", {m_valid, m_last, w}, prev_out);
        if (m_valid && !rdy) check("ready_o under stall", m_ready, 0);
        prev_stall = m_valid && !rdy;
        prev_out   = {m_valid, m_last, w};
        if (m_valid && rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious window: got %h expected none", w);
            end else begin
                e = exp_q.pop_front();
                check("window", {m_last, w}, e);
                cap_w.push_back(w);
                cap_l.push_back(m_last);
            end
        end
        acc = v && m_ready;
        if (acc) model_accept(px);
    endtask

    task automatic send_pixel(input logic [7:0] px);
        bit   acc;
        logic v;
        int   guard = 0;
        do begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            step(v, px, acc);
            guard++;
        end while (!acc && guard < 1000);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept timeout: got no accept expected accept of %0d", px);
        end
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < img_w * img_h; i++) send_pixel(8'((base + i) & 255));
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1'b0, 8'd0, acc);
    endtask

    task automatic begin_scen(input bit s, input int w, input int h);
        sel   = s;
        img_w = w;
        img_h = h;
        cap_w.delete();
        cap_l.delete();
    endtask

    task automatic end_scen(input string name, input int nwin, input int nlast);
        int lasts = 0;
        idle(4);
        foreach (cap_l[i]) if (cap_l[i]) lasts++;
        check({name, " window count"}, cap_w.size(), nwin);
        check({name, " last count"}, lasts, nlast);
        check({name, " leftover expected"}, exp_q.size(), 0);
    endtask

    task automatic check_table(input string name, input int frames);
        foreach (tbl[i]) begin
            if (tbl[i].idx < 4 * frames) begin
                if (tbl[i].idx < cap_w.size())
                    check({name, " table window"}, {cap_l[tbl[i].idx], cap_w[tbl[i].idx]},
                          {tbl[i].last, tbl[i].w});
                else
                    check({name, " table window missing"}, cap_w.size(), tbl[i].idx + 1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{idx: 0, last: 1'b0, w: {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}};
        tbl[1] = '{idx: 1, last: 1'b0, w: {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11}};
        tbl[2] = '{idx: 2, last: 1'b0, w: {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14}};
        tbl[3] = '{idx: 3, last: 1'b1, w: {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}};
        tbl[4] = '{idx: 4, last: 1'b0,
                   w: {8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110}};
        tbl[5] = '{idx: 7, last: 1'b1,
                   w: {8'd105, 8'd106, 8'd107, 8'd109, 8'd110, 8'd111, 8'd113, 8'd114, 8'd115}};

        #2;
        check("reset outputs", {m_valid, m_last, m_pack()}, 0);
        check("reset ready_o", m_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;

        begin_scen(1'b0, 4, 4);
        send_frame(0);
        end_scen("plain", 4, 1);
        check_table("plain", 1);

        begin_scen(1'b0, 4, 4);
        stall_left = 5;
        send_frame(0);
        end_scen("stall", 4, 1);
        check_table("stall", 1);
        check("stall cycles used", stall_left, 0);

        begin_scen(1'b0, 4, 4);
        send_frame(0);
        send_frame(100);
        end_scen("b2b", 8, 2);
        check_table("b2b", 2);

        begin_scen(1'b0, 4, 4);
        for (int i = 0; i < 7; i++) send_pixel(8'(i));
        @(negedge clk);
        valid_in = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("async reset clears", {m_valid, m_last, m_pack()}, 0);
        exp_q.delete();
        mr = 0;
        mc = 0;
        prev_stall = 0;
        @(negedge clk);
        reset_n = 1'b1;
        send_frame(0);
        end_scen("after reset", 4, 1);
        check_table("after reset", 1);

        begin_scen(1'b1, RW_W, RW_H);
        gaps     = 1;
        rand_rdy = 1;
        send_frame(0);
        send_frame(50);
        gaps     = 0;
        rand_rdy = 0;
        end_scen("random", 2 * (RW_W - 2) * (RW_H - 2), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
